// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the memory-stage control and the word-addressed data memory.
// Sub-word stores are done as a read-modify-write; misaligned or illegal requests never reach memory.
module mem_access_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [6:0]  dm_addr,
    output logic        dm_wr,
    output logic [31:0] dm_din,
    input  logic [31:0] dm_dout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WRITE,
        S_DONE
    } state_t;

    state_t      state;

    logic        l_we;
    logic        l_sext;
    logic [1:0]  l_size;
    logic [8:0]  l_addr;
    logic [31:0] l_wdata;

    logic        l_bad;
    logic        req_bad;
    logic        req_word_store;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_val;
    logic [31:0] merged;

    logic        unused_addr_hi;
    assign unused_addr_hi = ^addr[31:9];

    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'b00:   return 1'b0;
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    // The request-side check lets a word store raise dm_wr on the accept edge,
    // so the write lands in ACCESS while dm_wr stays a registered output.
    always_comb begin
        l_bad          = misaligned(l_size, l_addr[1:0]);
        req_bad        = misaligned(size, addr[1:0]);
        req_word_store = we && (size == 2'b10) && !req_bad;
    end

    always_comb begin
        byte_lane = dm_dout[{l_addr[1:0], 3'b000} +: 8];
        half_lane = dm_dout[{l_addr[1], 4'b0000} +: 16];
        load_val  = dm_dout;
        merged    = dm_dout;
        case (l_size)
            2'b00: begin
                load_val = {{24{l_sext & byte_lane[7]}}, byte_lane};
                merged[{l_addr[1:0], 3'b000} +: 8] = l_wdata[7:0];
            end
            2'b01: begin
                load_val = {{16{l_sext & half_lane[15]}}, half_lane};
                merged[{l_addr[1], 4'b0000} +: 16] = l_wdata[15:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            l_we    <= 1'b0;
            l_sext  <= 1'b0;
            l_size  <= '0;
            l_addr  <= '0;
            l_wdata <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            rdata   <= '0;
            dm_addr <= '0;
            dm_wr   <= 1'b0;
            dm_din  <= '0;
        end else begin
            dm_wr  <= 1'b0;
            dm_din <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
            case (state)
                S_ACCESS: begin
                    if (l_bad) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else if (!l_we) begin
                        rdata <= load_val;
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else if (l_size == 2'b10) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        dm_wr  <= 1'b1;
                        dm_din <= merged;
                        state  <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    state <= S_DONE;
                    done  <= 1'b1;
                end
                default: begin
                    // IDLE and DONE both sample req, so a held req restarts at the edge leaving DONE.
                    busy  <= 1'b0;
                    state <= S_IDLE;
                    if (req) begin
                        l_we    <= we;
                        l_sext  <= sext;
                        l_size  <= size;
                        l_addr  <= addr[8:0];
                        l_wdata <= wdata;
                        dm_addr <= addr[8:2];
                        busy    <= 1'b1;
                        state   <= S_ACCESS;
                        if (req_word_store) begin
                            dm_wr  <= 1'b1;
                            dm_din <= wdata;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios plus randomized traffic checked
// against a byte-lane arithmetic model of memory and load results.
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [6:0]  dm_addr;
    logic        dm_wr;
    logic [31:0] dm_din;
    logic [31:0] dm_dout;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [128] = '{default: 32'h0};
    logic [31:0] ref_mem [128];
    logic [31:0] ref_rdata;

    int          o_lat, o_wr_cnt, o_wr_cyc;
    logic [6:0]  o_wr_addr;
    logic        o_err, o_din_bad, o_busy_acc, o_busy_after;

    mem_access_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .we      (we),
        .size    (size),
        .sext    (sext),
        .addr    (addr),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .rdata   (rdata),
        .dm_addr (dm_addr),
        .dm_wr   (dm_wr),
        .dm_din  (dm_din),
        .dm_dout (dm_dout)
    );

    assign dm_dout = mem[dm_addr];
    always @(posedge clk) if (dm_wr) mem[dm_addr] <= dm_din;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: memory as bytes in little-endian lanes, address taken modulo 512.
    task automatic ref_apply(input logic w, input logic [1:0] sz, input logic sx,
                             input logic [31:0] a, input logic [31:0] wd,
                             output logic exp_err, output int exp_lat);
        int unsigned idx, off, nb, sh;
        logic [31:0] old, mask, val;
        idx = (a % 512) / 4;
        off = a % 4;
        exp_lat = 2;
        exp_err = (sz == 2'd3) || (sz == 2'd1 && (off % 2) != 0) || (sz == 2'd2 && off != 0);
        if (exp_err) return;
        nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        sh   = 8 * off;
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
        old  = ref_mem[idx];
        if (w) begin
            ref_mem[idx] = (old & ~(mask << sh)) | ((wd & mask) << sh);
            if (nb < 4) exp_lat = 3;
        end else begin
            val = (old >> sh) & mask;
            if (sx && nb < 4 && val[8 * nb - 1]) val = val | ~mask;
            ref_rdata = val;
        end
    endtask

    // Drives one request and records what the DUT did; comparisons are left to the callers.
    task automatic run_txn(input logic w, input logic [1:0] sz, input logic sx,
                           input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        req = 1'b1; we = w; size = sz; sext = sx; addr = a; wdata = wd;
        @(posedge clk); #1;
        req = 1'b0;
        o_busy_acc = busy;
        o_lat = -1; o_wr_cnt = 0; o_wr_cyc = -1; o_wr_addr = '0; o_err = 1'b0; o_din_bad = 1'b0;
        for (int c = 1; c <= 8 && o_lat < 0; c++) begin
            if (dm_wr) begin
                o_wr_cnt++;
                if (o_wr_cyc < 0) begin o_wr_cyc = c; o_wr_addr = dm_addr; end
            end else if (dm_din !== 32'h0) begin
                o_din_bad = 1'b1;
            end
            if (done) begin
                o_lat = c; o_err = err;
            end else begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        o_busy_after = busy;
    endtask

    task automatic test_reset();
        req = 1'b0; we = 1'b0; size = '0; sext = 1'b0; addr = '0; wdata = '0;
        rst = 1'b0;
        #1 rst = 1'b1;
        @(negedge clk); @(negedge clk);
        checks++; if ({busy, done, err, dm_wr} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {busy, done, err, dm_wr}); end
        checks++; if ({rdata, dm_addr, dm_din} !== '0) begin errors++; $display("FAIL reset_data: rdata=%h dm_addr=%h dm_din=%h want 0", rdata, dm_addr, dm_din); end
        rst = 1'b0;
        ref_rdata = '0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_word_store_load();
        logic e; int l;
        ref_apply(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, e, l);
        run_txn(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
        checks++; if (o_busy_acc !== 1'b1) begin errors++; $display("FAIL ws_busy: got %b want 1", o_busy_acc); end
        checks++; if (o_wr_cyc !== 1 || o_wr_cnt !== 1) begin errors++; $display("FAIL ws_wr_cycle: cyc=%0d cnt=%0d want cyc=1 cnt=1", o_wr_cyc, o_wr_cnt); end
        checks++; if (o_wr_addr !== 7'd4) begin errors++; $display("FAIL ws_dm_addr: got %0d want 4", o_wr_addr); end
        checks++; if (o_lat !== 2) begin errors++; $display("FAIL ws_latency: got %0d want 2", o_lat); end
        checks++; if (mem[4] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ws_mem: got %h want deadbeef", mem[4]); end
        ref_apply(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, e, l);
        run_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        checks++; if (o_lat !== 2) begin errors++; $display("FAIL wl_latency: got %0d want 2", o_lat); end
        checks++; if (rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wl_rdata: got %h want deadbeef", rdata); end
        checks++; if (o_err !== 1'b0 || o_wr_cnt !== 0) begin errors++; $display("FAIL wl_err_wr: err=%b wr=%0d want 0 0", o_err, o_wr_cnt); end
        checks++; if (o_busy_after !== 1'b0) begin errors++; $display("FAIL wl_busy_fall: got %b want 0", o_busy_after); end
    endtask

    task automatic test_subword_rmw();
        logic e; int l;
        ref_apply(1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344, e, l);
        run_txn(1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344);
        ref_apply(1'b1, 2'd0, 1'b0, 32'h12, 32'h0000_00AB, e, l);
        run_txn(1'b1, 2'd0, 1'b0, 32'h12, 32'h0000_00AB);
        checks++; if (mem[4] !== 32'h11AB_3344) begin errors++; $display("FAIL rmw_mem: got %h want 11ab3344", mem[4]); end
        checks++; if (o_wr_cyc !== 2 || o_wr_cnt !== 1) begin errors++; $display("FAIL rmw_wr_cycle: cyc=%0d cnt=%0d want cyc=2 cnt=1", o_wr_cyc, o_wr_cnt); end
        checks++; if (o_lat !== 3) begin errors++; $display("FAIL rmw_latency: got %0d want 3", o_lat); end
        checks++; if (o_din_bad !== 1'b0) begin errors++; $display("FAIL rmw_din_idle: got %b want 0", o_din_bad); end
    endtask

    task automatic test_extension();
        logic e; int l;
        ref_apply(1'b0, 2'd0, 1'b1, 32'h12, 32'h0, e, l);
        run_txn(1'b0, 2'd0, 1'b1, 32'h12, 32'h0);
        checks++; if (rdata !== 32'hFFFF_FFAB) begin errors++; $display("FAIL ext_lb_s: got %h want ffffffab", rdata); end
        ref_apply(1'b0, 2'd0, 1'b0, 32'h12, 32'h0, e, l);
        run_txn(1'b0, 2'd0, 1'b0, 32'h12, 32'h0);
        checks++; if (rdata !== 32'h0000_00AB) begin errors++; $display("FAIL ext_lb_u: got %h want 000000ab", rdata); end
        ref_apply(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, e, l);
        run_txn(1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
        checks++; if (rdata !== 32'h0000_11AB) begin errors++; $display("FAIL ext_lh_s: got %h want 000011ab", rdata); end
    endtask

    task automatic test_errors();
        logic e; int l;
        logic        ew  [3] = '{1'b1, 1'b0, 1'b1};
        logic [1:0]  esz [3] = '{2'd2, 2'd1, 2'd3};
        logic [31:0] ea  [3] = '{32'h13, 32'h11, 32'h10};
        for (int i = 0; i < 3; i++) begin
            ref_apply(ew[i], esz[i], 1'b1, ea[i], 32'hFFFF_FFFF, e, l);
            run_txn(ew[i], esz[i], 1'b1, ea[i], 32'hFFFF_FFFF);
            checks++; if (o_err !== 1'b1 || o_lat !== 2) begin errors++; $display("FAIL err_flag[%0d]: err=%b lat=%0d want 1 2", i, o_err, o_lat); end
            checks++; if (o_wr_cnt !== 0) begin errors++; $display("FAIL err_nowrite[%0d]: got %0d want 0", i, o_wr_cnt); end
            checks++; if (rdata !== 32'h0000_11AB) begin errors++; $display("FAIL err_rdata[%0d]: got %h want 000011ab", i, rdata); end
        end
        checks++; if (mem[4] !== 32'h11AB_3344) begin errors++; $display("FAIL err_mem: got %h want 11ab3344", mem[4]); end
    endtask

    task automatic test_reset_in_write();
        logic e; int l;
        ref_apply(1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFE_F00D, e, l);
        run_txn(1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFE_F00D);
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'd1; sext = 1'b0; addr = 32'h20; wdata = 32'h0000_1234;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        checks++; if (dm_wr !== 1'b1) begin errors++; $display("FAIL rst_in_write_wr: got %b want 1", dm_wr); end
        rst = 1'b1;
        #1;
        checks++; if ({busy, done, err, dm_wr} !== 4'b0) begin errors++; $display("FAIL rst_async_flags: got %b want 0000", {busy, done, err, dm_wr}); end
        checks++; if ({rdata, dm_addr, dm_din} !== '0) begin errors++; $display("FAIL rst_async_data: rdata=%h dm_addr=%h dm_din=%h want 0", rdata, dm_addr, dm_din); end
        @(negedge clk);
        rst = 1'b0;
        ref_rdata = '0;
        @(posedge clk); #1;
        checks++; if (mem[8] !== 32'hCAFE_F00D) begin errors++; $display("FAIL rst_mem_kept: got %h want cafef00d", mem[8]); end
        ref_apply(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, e, l);
        run_txn(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        checks++; if (o_lat !== 2 || rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL rst_recover: lat=%0d rdata=%h want 2 cafef00d", o_lat, rdata); end
    endtask

    task automatic test_back_to_back();
        logic e; int l;
        ref_apply(1'b1, 2'd2, 1'b0, 32'h4, 32'h0BAD_C0DE, e, l);
        run_txn(1'b1, 2'd2, 1'b0, 32'h4, 32'h0BAD_C0DE);
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'd2; sext = 1'b0; addr = 32'h10; wdata = '0;
        @(posedge clk); #1;
        addr = 32'h204;
        @(posedge clk); #1;
        checks++; if (done !== 1'b1 || rdata !== 32'h11AB_3344) begin errors++; $display("FAIL b2b_first: done=%b rdata=%h want 1 11ab3344", done, rdata); end
        @(posedge clk); #1;
        req = 1'b0;
        checks++; if (busy !== 1'b1 || done !== 1'b0 || dm_addr !== 7'd1) begin errors++; $display("FAIL b2b_accept: busy=%b done=%b dm_addr=%0d want 1 0 1", busy, done, dm_addr); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b1 || rdata !== 32'h0BAD_C0DE) begin errors++; $display("FAIL b2b_wrap: done=%b rdata=%h want 1 0badc0de", done, rdata); end
        ref_rdata = 32'h0BAD_C0DE;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", busy); end
    endtask

    task automatic test_random();
        logic w, sx, e_err;
        logic [1:0] sz;
        logic [31:0] a, wd;
        int e_lat;
        int unsigned idx;
        for (int n = 0; n < 150; n++) begin
            w   = 1'($urandom_range(0, 1));
            sz  = 2'($urandom_range(0, 3));
            sx  = 1'($urandom_range(0, 1));
            a   = $urandom & 32'hFFFF_FE3F;
            wd  = $urandom;
            idx = (a % 512) / 4;
            ref_apply(w, sz, sx, a, wd, e_err, e_lat);
            run_txn(w, sz, sx, a, wd);
            checks++; if (o_lat !== e_lat) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", n, o_lat, e_lat); end
            checks++; if (o_err !== e_err) begin errors++; $display("FAIL rnd_err[%0d]: got %b want %b", n, o_err, e_err); end
            checks++; if (o_wr_cnt !== ((w && !e_err) ? 1 : 0)) begin errors++; $display("FAIL rnd_wr_count[%0d]: got %0d want %0d", n, o_wr_cnt, (w && !e_err) ? 1 : 0); end
            checks++; if (rdata !== ref_rdata) begin errors++; $display("FAIL rnd_rdata[%0d]: got %h want %h", n, rdata, ref_rdata); end
            checks++; if (mem[idx] !== ref_mem[idx]) begin errors++; $display("FAIL rnd_mem[%0d]: word %0d got %h want %h", n, idx, mem[idx], ref_mem[idx]); end
            checks++; if (o_din_bad !== 1'b0 || o_busy_after !== 1'b0) begin errors++; $display("FAIL rnd_idle[%0d]: din_bad=%b busy=%b want 0 0", n, o_din_bad, o_busy_after); end
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) ref_mem[i] = 32'h0;
        test_reset();
        test_word_store_load();
        test_subword_rmw();
        test_extension();
        test_errors();
        test_reset_in_write();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
